// File: rtl/game_pkg.sv
// Shared game types and constants.
// Used by the flow controller and the pipe/bird renderers.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DYING = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  localparam int SCORE_WIDTH = 10;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int BIRD_X   = 160;

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Flow controller <-> button/VGA/renderer signal bundle.
// master: controller side; slave: environment side.
interface game_flow_ctrl_if
  import game_pkg::*;
#(
  parameter int SCORE_W = SCORE_WIDTH
);
  logic               start_btn;
  logic               frame_start;
  logic               bird_pixel;
  logic               pipe_pixel;
  logic               bird_floor;
  logic               pass_pulse;
  logic               pipe_enable;
  logic               pipe_reset;
  logic               bird_enable;
  logic               move_tick;
  state_e             state;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] high_score;

  modport master (
    input  start_btn, frame_start,
    input  bird_pixel, pipe_pixel,
    input  bird_floor, pass_pulse,
    output pipe_enable, pipe_reset,
    output bird_enable, move_tick,
    output state, score, high_score
  );

  modport slave (
    output start_btn, frame_start,
    output bird_pixel, pipe_pixel,
    output bird_floor, pass_pulse,
    input  pipe_enable, pipe_reset,
    input  bird_enable, move_tick,
    input  state, score, high_score
  );
endinterface

// File: rtl/game_flow_ctrl_tick_divider.sv
// Loadable-period pulse generator.
// Ports: clk, reset_n, en, period, tick.
module tick_divider #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic [W-1:0] period,
  output logic         tick
);
  logic [W-1:0] r_cnt;
  logic [W-1:0] r_per;
  logic         r_tick;
  logic [W-1:0] w_per;
  logic         w_wrap;

  // period is sampled only at the start of a count
  assign w_per  = (r_cnt == '0) ? period : r_per;
  assign w_wrap = (r_cnt >= (w_per - W'(1)));
  assign tick   = r_tick;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_per  <= '0;
      r_tick <= 1'b0;
    end else if (!en) begin
      r_cnt  <= '0;
      r_per  <= period;
      r_tick <= 1'b0;
    end else begin
      r_per  <= w_per;
      r_tick <= w_wrap;
      r_cnt  <= w_wrap ? '0 : r_cnt + W'(1);
    end
  end
endmodule

// File: rtl/game_flow_ctrl.sv
// Game sequencer: flow FSM, collision, scoring, move tick.
// Ports: clk, reset_n, io (game_flow_ctrl_if.master).
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int TICK_DIV      = 1_000_000,
  parameter int MIN_TICK_DIV  = 400_000,
  parameter int TICK_STEP     = 100_000,
  parameter int SPEEDUP_EVERY = 8,
  parameter int DEATH_FRAMES  = 60,
  parameter int SCORE_W       = SCORE_WIDTH
) (
  input logic             clk,
  input logic             reset_n,
  game_flow_ctrl_if.master io
);
  localparam int CW  = $clog2(TICK_DIV + 1);
  localparam int FW  = $clog2(DEATH_FRAMES + 1);
  localparam int SPW = (SPEEDUP_EVERY > 1) ?
                       $clog2(SPEEDUP_EVERY) : 1;

  localparam logic [CW-1:0] DIV_INIT = CW'(TICK_DIV);
  localparam logic [CW-1:0] DIV_MIN  = CW'(MIN_TICK_DIV);
  localparam logic [CW-1:0] DIV_STEP = CW'(TICK_STEP);
  localparam logic [FW-1:0] FR_LAST  = FW'(DEATH_FRAMES - 1);
  localparam logic [SCORE_W-1:0] S_MAX = '1;

  state_e             r_state;
  state_e             w_nxt;
  logic               r_btn_q;
  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] r_high;
  logic [CW-1:0]      r_div;
  logic [FW-1:0]      r_frame;

  logic               w_idle, w_run, w_dying, w_over;
  logic               w_edge, w_hit, w_inc, w_fr_last;
  logic [SCORE_W-1:0] w_score_p1;
  logic               w_speedup;
  logic [CW-1:0]      w_next_div;

  assign w_idle  = (r_state == ST_IDLE);
  assign w_run   = (r_state == ST_RUN);
  assign w_dying = (r_state == ST_DYING);
  assign w_over  = (r_state == ST_OVER);

  assign w_edge = io.start_btn & ~r_btn_q;
  assign w_hit  = (io.bird_pixel & io.pipe_pixel)
                | io.bird_floor;

  // hit outranks a pass in the same cycle
  assign w_inc = w_run & io.pass_pulse & ~w_hit
               & (r_score != S_MAX);
  assign w_score_p1 = r_score + SCORE_W'(1);
  assign w_speedup  = (w_score_p1[SPW-1:0] == '0);
  assign w_next_div = ((r_div - DIV_MIN) > DIV_STEP) ?
                      (r_div - DIV_STEP) : DIV_MIN;
  assign w_fr_last  = (r_frame == FR_LAST);

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_edge) w_nxt = ST_RUN;
      ST_RUN:   if (w_hit) w_nxt = ST_DYING;
      ST_DYING: if (io.frame_start && w_fr_last)
                  w_nxt = ST_OVER;
      ST_OVER:  if (w_edge) w_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    io.pipe_reset  = 1'b0;
    io.pipe_enable = 1'b0;
    io.bird_enable = 1'b0;
    unique case (1'b1)
      w_idle:  io.pipe_reset = 1'b1;
      w_run: begin
        io.pipe_enable = 1'b1;
        io.bird_enable = 1'b1;
      end
      w_dying: io.bird_enable = 1'b1;
      w_over:  ;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_btn_q <= 1'b0;
      r_score <= '0;
      r_high  <= '0;
      r_div   <= DIV_INIT;
      r_frame <= '0;
    end else begin
      r_state <= w_nxt;
      r_btn_q <= io.start_btn;
      if (w_idle && w_edge) begin
        r_score <= '0;
        r_div   <= DIV_INIT;
      end else if (w_inc) begin
        r_score <= w_score_p1;
        if (w_speedup) r_div <= w_next_div;
      end
      if (w_run && w_hit)
        r_frame <= '0;
      else if (w_dying && io.frame_start)
        r_frame <= r_frame + FW'(1);
      if (w_dying && io.frame_start && w_fr_last
          && (r_score > r_high))
        r_high <= r_score;
    end
  end

  tick_divider #(.W(CW)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (w_run),
    .period  (r_div),
    .tick    (io.move_tick)
  );

  assign io.state      = r_state;
  assign io.score      = r_score;
  assign io.high_score = r_high;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl.
// Directed steps plus randomized games against a score/period model.
module tb_game_flow_ctrl;
  import game_pkg::*;

  localparam int TD = 10;
  localparam int MD = 5;
  localparam int TS = 3;
  localparam int SE = 2;
  localparam int DF = 60;
  localparam int SW = 3;
  localparam int SMAX = (1 << SW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  game_flow_ctrl_if #(.SCORE_W(SW)) bus ();

  game_flow_ctrl #(
    .TICK_DIV      (TD),
    .MIN_TICK_DIV  (MD),
    .TICK_STEP     (TS),
    .SPEEDUP_EVERY (SE),
    .DEATH_FRAMES  (DF),
    .SCORE_W       (SW)
  ) dut (
    .clk     (clk),
    .reset_n (rst_n),
    .io      (bus)
  );

  int total = 0;
  int bad = 0;
  int high_ref = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  function automatic int exp_score(input int passes);
    return (passes > SMAX) ? SMAX : passes;
  endfunction

  // period after reaching score s: one step per SE points
  function automatic int exp_period(input int s);
    int p;
    p = TD - TS * (s / SE);
    return (p < MD) ? MD : p;
  endfunction

  task automatic pass1();
    bus.pass_pulse = 1'b1;
    cyc();
    bus.pass_pulse = 1'b0;
    cyc();
  endtask

  task automatic frame1(input int gap);
    bus.frame_start = 1'b1;
    cyc();
    bus.frame_start = 1'b0;
    cyc(1 + gap);
  endtask

  task automatic gap(output int g);
    int n;
    n = 0;
    while (bus.move_tick !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    if (n >= 40) begin
      g = -1;
      return;
    end
    g = 0;
    do begin
      cyc();
      g++;
    end while (bus.move_tick !== 1'b1 && g < 40);
  endtask

  task automatic start_game();
    bus.start_btn = 1'b1;
    cyc();
    check("start_run", 32'(bus.state), 32'(ST_RUN));
    check("start_score", 32'(bus.score), 0);
    bus.start_btn = 1'b0;
    cyc();
  endtask

  task automatic restart();
    bus.start_btn = 1'b1;
    cyc();
    check("over_idle", 32'(bus.state), 32'(ST_IDLE));
    bus.start_btn = 1'b0;
    cyc();
    start_game();
  endtask

  task automatic die(input bit floor);
    if (floor) bus.bird_floor = 1'b1;
    else begin
      bus.bird_pixel = 1'b1;
      bus.pipe_pixel = 1'b1;
    end
    cyc();
    bus.bird_floor = 1'b0;
    bus.bird_pixel = 1'b0;
    bus.pipe_pixel = 1'b0;
    check("hit_dying", 32'(bus.state), 32'(ST_DYING));
  endtask

  int g;
  int ticks;
  int n;

  initial begin
    bus.start_btn   = 1'b0;
    bus.frame_start = 1'b0;
    bus.bird_pixel  = 1'b0;
    bus.pipe_pixel  = 1'b0;
    bus.bird_floor  = 1'b0;
    bus.pass_pulse  = 1'b0;

    cyc(3);
    check("rst_state", 32'(bus.state), 32'(ST_IDLE));
    check("rst_score", 32'(bus.score), 0);
    check("rst_high", 32'(bus.high_score), 0);
    check("rst_tick", 32'(bus.move_tick), 0);
    check("rst_preset", 32'(bus.pipe_reset), 1);
    check("rst_pen", 32'(bus.pipe_enable), 0);
    check("rst_ben", 32'(bus.bird_enable), 0);
    rst_n = 1'b1;
    cyc(2);

    // game 1: held button, tick period, score, death
    bus.start_btn = 1'b1;
    cyc();
    check("g1_run", 32'(bus.state), 32'(ST_RUN));
    check("g1_preset", 32'(bus.pipe_reset), 0);
    check("g1_pen", 32'(bus.pipe_enable), 1);
    check("g1_ben", 32'(bus.bird_enable), 1);
    cyc(5);
    check("g1_held", 32'(bus.state), 32'(ST_RUN));
    bus.start_btn = 1'b0;
    cyc();
    gap(g);
    check("g1_gap", g, TD);
    repeat (3) pass1();
    check("g1_score", 32'(bus.score), 3);
    die(1'b0);
    check("g1_pen_dy", 32'(bus.pipe_enable), 0);
    check("g1_ben_dy", 32'(bus.bird_enable), 1);
    ticks = 0;
    repeat (20) begin
      cyc();
      if (bus.move_tick === 1'b1) ticks++;
    end
    check("g1_no_tick", ticks, 0);
    repeat (DF - 1) frame1(0);
    check("g1_dying59", 32'(bus.state), 32'(ST_DYING));
    frame1(0);
    check("g1_over", 32'(bus.state), 32'(ST_OVER));
    check("g1_high", 32'(bus.high_score), 3);
    check("g1_ben_ov", 32'(bus.bird_enable), 0);

    // OVER -> IDLE with held button, then fresh press
    bus.start_btn = 1'b1;
    cyc();
    check("ov_idle", 32'(bus.state), 32'(ST_IDLE));
    check("ov_preset", 32'(bus.pipe_reset), 1);
    cyc(3);
    check("ov_held", 32'(bus.state), 32'(ST_IDLE));
    bus.start_btn = 1'b0;
    cyc();
    start_game();
    check("g2_high", 32'(bus.high_score), 3);

    // game 2: speed-up steps and saturation
    gap(g);
    check("g2_gap0", g, TD);
    for (int s = 1; s <= 6; s++) begin
      pass1();
      if (s % 2 == 0) begin
        gap(g);
        check("g2_gap", g, exp_period(s));
      end
    end
    repeat (3) pass1();
    check("g2_sat", 32'(bus.score), SMAX);
    gap(g);
    check("g2_gap_sat", g, exp_period(SMAX));

    // asynchronous reset mid-run
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_state", 32'(bus.state), 32'(ST_IDLE));
    check("ar_score", 32'(bus.score), 0);
    check("ar_high", 32'(bus.high_score), 0);
    check("ar_preset", 32'(bus.pipe_reset), 1);
    @(negedge clk);
    cyc();
    rst_n = 1'b1;
    cyc();
    high_ref = 0;

    // game 3: pass and hit in the same cycle
    start_game();
    repeat (5) pass1();
    check("g3_score", 32'(bus.score), 5);
    bus.pass_pulse = 1'b1;
    die(1'b1);
    bus.pass_pulse = 1'b0;
    check("g3_keep", 32'(bus.score), 5);
    repeat (DF) frame1(0);
    check("g3_over", 32'(bus.state), 32'(ST_OVER));
    high_ref = 5;
    check("g3_high", 32'(bus.high_score), high_ref);

    // randomized games against the model
    for (int k = 0; k < 6; k++) begin
      restart();
      n = $urandom_range(0, 9);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 1) bus.bird_pixel = 1'b1;
        else bus.pipe_pixel = 1'b1;
        cyc();
        bus.bird_pixel = 1'b0;
        bus.pipe_pixel = 1'b0;
        pass1();
        cyc($urandom_range(0, 2));
      end
      check("rg_alive", 32'(bus.state), 32'(ST_RUN));
      check("rg_score", 32'(bus.score), exp_score(n));
      gap(g);
      check("rg_gap", g, exp_period(exp_score(n)));
      die(1'($urandom_range(0, 1)));
      repeat (DF) frame1($urandom_range(0, 2));
      check("rg_over", 32'(bus.state), 32'(ST_OVER));
      if (exp_score(n) > high_ref) high_ref = exp_score(n);
      check("rg_high", 32'(bus.high_score), high_ref);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
